input_vc_arbiter: RTL and testbench
===================================

INPUT_VC_ARBITER -- requirements
Module: input_vc_arbiter

Interface
REQ-001 Parameter vc_num, default 3: VCs per priority class.
REQ-002 Parameter prio_num, default 2: priority classes; N = vc_num*prio_num input VCs, W = $clog2(N).
REQ-003 Parameter output_num, default 8: switch outputs.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 resetn  input  1  reset, synchronous, active-low.
REQ-006 has_packet  input  N  per-VC "head packet present" level.
REQ-007 dest_i  input  N x output_num  per-VC one-hot destination output; valid while has_packet[i]=1.
REQ-008 output_vc_i  input  N x W  per-VC requested output VC; valid while has_packet[i]=1.
REQ-009 last  input  1  final beat of current packet accepted this cycle.
REQ-010 o_req  output  output_num  one-hot request to switch allocator.
REQ-011 o_req_vc  output  W  output VC of request.
REQ-012 i_gnt  input  1  allocator grant for o_req.
REQ-013 cts  output  1  clear-to-send for selected VC.
REQ-014 selected_vc  output  W  VC being requested/served.

Function
REQ-015 VC i SHALL belong to class p = i / vc_num; class prio_num-1 highest.
REQ-016 VC i SHALL be eligible when has_packet[i]=1 and dest_i[i] is exactly one-hot; zero or multi-hot dest makes VC ineligible (no request, no error).
REQ-017 Selection SHALL pick the highest class with any eligible VC, then round-robin within it starting at that class's pointer rr[p] (range 0..vc_num-1), wrapping vc_num-1 -> 0.
REQ-018 FSM states SHALL be IDLE, REQ, XFER.
REQ-019 IDLE: if any VC eligible, latch selected_vc, dest_i[sel], output_vc_i[sel] and go to REQ next cycle; else stay; o_req=0, cts=0.
REQ-020 REQ: o_req = latched dest, o_req_vc = latched output VC, held stable regardless of input changes; on i_gnt=1 go to XFER next cycle.
REQ-021 REQ: if has_packet[selected_vc] drops before i_gnt, return to IDLE next cycle without pointer update; simultaneous drop and i_gnt SHALL take the grant (go XFER).
REQ-022 XFER: cts=1, o_req=0, selected_vc held; stay until last=1.
REQ-023 XFER with last=1: cts SHALL remain 1 in that cycle, state -> IDLE next cycle with cts=0, rr[p of selected] <- (selected local index + 1) mod vc_num.
REQ-024 last outside XFER and i_gnt outside REQ SHALL be ignored.
REQ-025 Minimum per-packet overhead: has_packet rise at cycle t -> REQ at t+1 -> (i_gnt at t+1) cts=1 at t+2; next packet from IDLE at cycle after last.
REQ-026 Pointers of classes not served SHALL not change; lower class SHALL starve while higher class has eligible VCs (strict priority, by design).
REQ-027 Outputs o_req, o_req_vc, cts, selected_vc SHALL be registered.

Reset
REQ-028 resetn=0 at a rising edge SHALL force state IDLE, all rr[p]=0, o_req=0, o_req_vc=0, cts=0, selected_vc=0 from next cycle, including mid-REQ or mid-XFER; an in-flight packet is abandoned.

Verification
REQ-029 Single VC: vc_num=3, prio_num=2, has_packet=6'b000100, dest_i[2]=8'h10, output_vc_i[2]=2 -> next cycle o_req=8'h10, o_req_vc=2, selected_vc=2; i_gnt pulse -> cts=1 next cycle; last -> cts=0 cycle after.
REQ-030 Priority: has_packet=6'b001001 (VC0 class 0, VC3 class 1) -> VC3 served first, then VC0.
REQ-031 Round-robin wrap: has_packet=6'b000111 held, last after each grant -> service order 0,1,2,0 with rr[0] wrapping 2 -> 0.
REQ-032 Bad dest: has_packet=6'b000011, dest_i[0]=0, dest_i[1]=8'h01 -> only VC1 requested; dest_i[0]=8'h0C multi-hot likewise ignored.
REQ-033 Withdraw and reset: in REQ drop has_packet[sel] -> IDLE, rr unchanged; assert resetn=0 during XFER -> cts=0, selected_vc=0 next cycle.

Source files
------------

// File: rtl/input_vc_arbiter_if.sv
// Handshake bundle between the per-VC input buffers, the VC arbiter and the
// switch allocator.
interface input_vc_arbiter_if #(
  parameter int vc_num     = 3,
  parameter int prio_num   = 2,
  parameter int output_num = 8
);
  localparam int n = vc_num * prio_num;
  localparam int w = (n > 1) ? $clog2(n) : 1;

  logic [n-1:0]                 has_packet;
  logic [n-1:0][output_num-1:0] dest_i;
  logic [n-1:0][w-1:0]          output_vc_i;
  logic                         last;
  logic [output_num-1:0]        o_req;
  logic [w-1:0]                 o_req_vc;
  logic                         i_gnt;
  logic                         cts;
  logic [w-1:0]                 selected_vc;

  modport master (
    output has_packet, dest_i, output_vc_i, last, i_gnt,
    input  o_req, o_req_vc, cts, selected_vc
  );

  modport slave (
    input  has_packet, dest_i, output_vc_i, last, i_gnt,
    output o_req, o_req_vc, cts, selected_vc
  );
endinterface

// File: rtl/input_vc_arbiter.sv
// Input-port VC arbiter: strict priority between classes, round-robin inside a
// class, one packet at a time requested from the switch allocator.
//
// state | meaning
// IDLE  | no packet in flight; pick next eligible VC
// REQ   | request held towards the allocator, waiting for grant
// XFER  | granted; cts high until the last beat is accepted
module input_vc_arbiter #(
  parameter int vc_num     = 3,
  parameter int prio_num   = 2,
  parameter int output_num = 8
) (
  input logic                clk,
  input logic                resetn,
  input_vc_arbiter_if.slave  bus
);
  localparam int n  = vc_num * prio_num;
  localparam int w  = (n > 1) ? $clog2(n) : 1;
  localparam int rw = (vc_num > 1) ? $clog2(vc_num) : 1;

  typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;

  state_t                state_q, state_d;
  logic [rw-1:0]         rr_q [prio_num];
  logic [rw-1:0]         rr_d [prio_num];
  logic [w-1:0]          sel_q, sel_d;
  logic [w-1:0]          ovc_q, ovc_d;
  logic [output_num-1:0] req_q, req_d;
  logic                  cts_q, cts_d;

  logic [n-1:0]          eligible;
  logic                  any_elig;
  logic [w-1:0]          pick;

  // Highest class first; within a class scan from its pointer, wrapping.
  always_comb begin
    int lidx;
    logic [w-1:0] idx;
    lidx     = 0;
    idx      = '0;
    pick     = '0;
    any_elig = 1'b0;
    for (int i = 0; i < n; i++) begin
      eligible[i] = bus.has_packet[i] && $onehot(bus.dest_i[i]);
    end
    for (int p = prio_num - 1; p >= 0; p--) begin
      for (int k = 0; k < vc_num; k++) begin
        lidx = int'(rr_q[p]) + k;
        if (lidx >= vc_num) lidx = lidx - vc_num;
        idx = w'(p * vc_num + lidx);
        if (!any_elig && eligible[idx]) begin
          any_elig = 1'b1;
          pick     = idx;
        end
      end
    end
  end

  always_comb begin
    int sl;
    state_d = state_q;
    rr_d    = rr_q;
    sel_d   = sel_q;
    ovc_d   = ovc_q;
    req_d   = req_q;
    cts_d   = cts_q;
    sl      = int'(sel_q) % vc_num;
    case (state_q)
      IDLE: begin
        req_d = '0;
        cts_d = 1'b0;
        if (any_elig) begin
          sel_d   = pick;
          req_d   = bus.dest_i[pick];
          ovc_d   = bus.output_vc_i[pick];
          state_d = REQ;
        end
      end
      REQ: begin
        // A grant in the same cycle as a withdraw still wins.
        if (bus.i_gnt) begin
          state_d = XFER;
          req_d   = '0;
          cts_d   = 1'b1;
        end else if (!bus.has_packet[sel_q]) begin
          state_d = IDLE;
          req_d   = '0;
        end
      end
      XFER: begin
        cts_d = 1'b1;
        if (bus.last) begin
          state_d = IDLE;
          cts_d   = 1'b0;
          for (int p = 0; p < prio_num; p++) begin
            if (p == int'(sel_q) / vc_num) begin
              rr_d[p] = (sl == vc_num - 1) ? '0 : rw'(sl + 1);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      for (int p = 0; p < prio_num; p++) rr_q[p] <= '0;
      sel_q   <= '0;
      ovc_q   <= '0;
      req_q   <= '0;
      cts_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      sel_q   <= sel_d;
      ovc_q   <= ovc_d;
      req_q   <= req_d;
      cts_q   <= cts_d;
    end
  end

  assign bus.o_req       = req_q;
  assign bus.o_req_vc    = ovc_q;
  assign bus.cts         = cts_q;
  assign bus.selected_vc = sel_q;
endmodule

// File: tb/tb_input_vc_arbiter.sv
// Scoreboard bench for input_vc_arbiter: a priority/round-robin reference
// model predicts each request, a monitor compares when a request appears.
module tb_input_vc_arbiter;
  localparam int VC = 3;
  localparam int PR = 2;
  localparam int ON = 8;
  localparam int N  = VC * PR;
  localparam int W  = 3;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  input_vc_arbiter_if #(.vc_num(VC), .prio_num(PR), .output_num(ON)) bus ();
  input_vc_arbiter #(.vc_num(VC), .prio_num(PR), .output_num(ON)) dut (
    .clk(clk), .resetn(resetn), .bus(bus.slave));

  typedef struct {
    int            sel;
    logic [ON-1:0] dest;
    logic [W-1:0]  ovc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   rr_m[PR];
  int   lat = 0;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: highest class with an eligible VC; inside it the first eligible
  // local index at or after the pointer, else the lowest eligible one.
  function automatic int model_pick();
    int first, after, i;
    for (int p = PR - 1; p >= 0; p--) begin
      first = -1;
      after = -1;
      for (int l = 0; l < VC; l++) begin
        i = p * VC + l;
        if (bus.has_packet[i] && $countones(bus.dest_i[i]) == 1) begin
          if (first < 0) first = l;
          if (after < 0 && l >= rr_m[p]) after = l;
        end
      end
      if (after >= 0) return p * VC + after;
      if (first >= 0) return p * VC + first;
    end
    return -1;
  endfunction

  function automatic logic [ON-1:0] rand_dest();
    logic [ON-1:0] v;
    int r;
    r = $urandom_range(0, 9);
    v = 1;
    if (r == 0) return '0;
    if (r == 1) begin
      v = 3;
      return v << $urandom_range(0, ON - 2);
    end
    return v << $urandom_range(0, ON - 1);
  endfunction

  task automatic set_vc(input int i, input logic [ON-1:0] d, input logic [W-1:0] o);
    bus.dest_i[i]      = d;
    bus.output_vc_i[i] = o;
  endtask

  task automatic randomize_inputs();
    bus.has_packet = N'($urandom_range(0, (1 << N) - 1));
    for (int i = 0; i < N; i++) set_vc(i, rand_dest(), W'($urandom_range(0, 7)));
  endtask

  task automatic wait_req();
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (bus.o_req == 0 && lat < 6);
    check("req_seen", bus.o_req != 0, 1);
  endtask

  task automatic serve(input int sel, input logic [ON-1:0] dest, input logic [W-1:0] ovc,
                       input int gd, input int xl, input bit dwg, input bit perturb);
    for (int c = 0; c < gd; c++) begin
      if (perturb) begin
        randomize_inputs();
        bus.has_packet[sel] = 1'b1;
        bus.last = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      bus.last = 1'b0;
      check("hold_o_req", bus.o_req, dest);
      check("hold_o_req_vc", bus.o_req_vc, ovc);
      check("hold_sel", bus.selected_vc, sel);
    end
    bus.i_gnt = 1'b1;
    if (dwg) bus.has_packet[sel] = 1'b0;
    @(negedge clk);
    bus.i_gnt = 1'b0;
    check("cts_after_gnt", bus.cts, 1);
    check("o_req_in_xfer", bus.o_req, 0);
    check("sel_in_xfer", bus.selected_vc, sel);
    for (int c = 0; c < xl; c++) begin
      bus.i_gnt = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("cts_xfer", bus.cts, 1);
    end
    bus.i_gnt = 1'b0;
    bus.last = 1'b1;
    check("cts_last_cycle", bus.cts, 1);
    @(negedge clk);
    bus.last = 1'b0;
    check("cts_after_last", bus.cts, 0);
    check("o_req_after_last", bus.o_req, 0);
    rr_m[sel / VC] = (sel % VC + 1) % VC;
  endtask

  task automatic round(input int gd, input int xl, input bit dwg, input bit perturb);
    int   s;
    exp_t e;
    s = model_pick();
    if (s < 0) begin
      bus.i_gnt = 1'b1;
      repeat (3) begin
        @(negedge clk);
        check("idle_no_req", bus.o_req, 0);
        check("idle_no_cts", bus.cts, 0);
      end
      bus.i_gnt = 1'b0;
      return;
    end
    e.sel  = s;
    e.dest = bus.dest_i[s];
    e.ovc  = bus.output_vc_i[s];
    exp_q.push_back(e);
    wait_req();
    serve(s, e.dest, e.ovc, gd, xl, dwg, perturb);
  endtask

  // Monitor: every new request is compared with the oldest prediction.
  initial begin
    logic [ON-1:0] prev;
    exp_t e;
    prev = '0;
    forever begin
      @(negedge clk);
      if (bus.o_req != 0 && prev == 0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_req: got o_req %0h sel %0d expected none", bus.o_req, bus.selected_vc);
        end else begin
          e = exp_q.pop_front();
          check("sb_selected_vc", bus.selected_vc, e.sel);
          check("sb_o_req", bus.o_req, e.dest);
          check("sb_o_req_vc", bus.o_req_vc, e.ovc);
        end
      end
      prev = bus.o_req;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.has_packet = '0;
    bus.dest_i = '0;
    bus.output_vc_i = '0;
    bus.last = 1'b0;
    bus.i_gnt = 1'b0;
    for (int p = 0; p < PR; p++) rr_m[p] = 0;
    repeat (3) @(negedge clk);
    check("rst_o_req", bus.o_req, 0);
    check("rst_o_req_vc", bus.o_req_vc, 0);
    check("rst_cts", bus.cts, 0);
    check("rst_sel", bus.selected_vc, 0);
    resetn = 1'b1;
    @(negedge clk);

    // single VC with minimum latency
    set_vc(2, 8'h10, 3'd2);
    bus.has_packet = 6'b000100;
    round(0, 0, 1'b0, 1'b0);
    check("req_latency", lat, 1);

    // round-robin wrap within class 0
    set_vc(0, 8'h01, 3'd1);
    set_vc(1, 8'h02, 3'd4);
    set_vc(2, 8'h04, 3'd6);
    bus.has_packet = 6'b000111;
    repeat (4) round(1, 1, 1'b0, 1'b0);

    // class 1 beats class 0
    set_vc(3, 8'h08, 3'd5);
    bus.has_packet = 6'b001001;
    round(0, 2, 1'b0, 1'b0);
    bus.has_packet = 6'b000001;
    round(0, 0, 1'b0, 1'b0);

    // zero and multi-hot destinations are ineligible
    set_vc(0, 8'h00, 3'd0);
    set_vc(1, 8'h01, 3'd3);
    bus.has_packet = 6'b000011;
    round(0, 0, 1'b0, 1'b0);
    set_vc(0, 8'h0C, 3'd0);
    round(2, 0, 1'b0, 1'b0);

    // withdraw in REQ: pointer must not move
    set_vc(1, 8'h20, 3'd1);
    set_vc(2, 8'h40, 3'd2);
    bus.has_packet = 6'b000110;
    begin
      exp_t e;
      int s;
      s = model_pick();
      e.sel = s; e.dest = bus.dest_i[s]; e.ovc = bus.output_vc_i[s];
      exp_q.push_back(e);
      wait_req();
      bus.has_packet[s] = 1'b0;
      @(negedge clk);
      check("withdraw_o_req", bus.o_req, 0);
      check("withdraw_cts", bus.cts, 0);
    end
    bus.has_packet = 6'b000110;
    round(0, 0, 1'b0, 1'b0);

    // withdraw coincident with grant keeps the grant
    set_vc(0, 8'h80, 3'd7);
    bus.has_packet = 6'b000111;
    round(1, 1, 1'b1, 1'b0);

    // reset in the middle of a transfer
    bus.has_packet = 6'b000111;
    begin
      exp_t e;
      int s;
      s = model_pick();
      e.sel = s; e.dest = bus.dest_i[s]; e.ovc = bus.output_vc_i[s];
      exp_q.push_back(e);
      wait_req();
      bus.i_gnt = 1'b1;
      @(negedge clk);
      bus.i_gnt = 1'b0;
      check("pre_rst_cts", bus.cts, 1);
      resetn = 1'b0;
      @(negedge clk);
      check("xfer_rst_cts", bus.cts, 0);
      check("xfer_rst_sel", bus.selected_vc, 0);
      check("xfer_rst_o_req", bus.o_req, 0);
      check("xfer_rst_o_req_vc", bus.o_req_vc, 0);
      bus.has_packet = '0;
      resetn = 1'b1;
      for (int p = 0; p < PR; p++) rr_m[p] = 0;
      @(negedge clk);
    end
    bus.has_packet = 6'b000111;
    round(0, 0, 1'b0, 1'b0);

    // randomized traffic
    repeat (120) begin
      randomize_inputs();
      round($urandom_range(0, 3), $urandom_range(0, 4),
            $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)));
    end

    bus.has_packet = '0;
    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
